// File: rtl/fft_bitrev_reorder.sv
// Streaming ping-pong frame reorderer: natural-order samples in, bit-reversed
// (or natural, per-frame mode) samples out, with first-word-fall-through reads.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_err
);

  localparam int n_samp = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] idx_last = '1;

  logic [DATA_WIDTH-1:0] mem [2*n_samp];

  logic              wr_bank;
  logic              rd_bank;
  logic [LOG2_N-1:0] wr_idx;
  logic [LOG2_N-1:0] rd_idx;
  logic [LOG2_N-1:0] rd_addr;
  logic [1:0]        full;
  logic [1:0]        bank_mode;
  logic              accept;
  logic              xfer;
  logic              wr_done;
  logic              rd_done;

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] x);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2_N; i++) r[i] = x[LOG2_N-1-i];
    return r;
  endfunction

  assign in_ready  = !full[wr_bank];
  assign accept    = in_valid && in_ready;
  assign wr_done   = accept && (wr_idx == idx_last);

  assign out_valid = full[rd_bank];
  assign xfer      = out_valid && out_ready;
  assign rd_done   = xfer && (rd_idx == idx_last);
  assign rd_addr   = bank_mode[rd_bank] ? bitrev(rd_idx) : rd_idx;
  assign out_data  = out_valid ? mem[{rd_bank, rd_addr}] : '0;
  assign out_last  = out_valid && (rd_idx == idx_last);

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) mem[{wr_bank, wr_idx}] <= in_data;
  end

  // Write and read completions always hit different banks, so both full bits
  // can be updated in the same cycle without conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      full      <= 2'b00;
      bank_mode <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      if (accept) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == '0) bank_mode[wr_bank] <= mode;
        if (in_last != (wr_idx == idx_last)) frame_err <= 1'b1;
        if (wr_done) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (xfer) begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_done) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: vector table on reordered frames plus
// streaming, backpressure, framing-error and mid-frame reset sequences.
module tb_fft_bitrev_reorder;

  localparam int DW = 16;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic          frame_err;
  logic [DW-1:0] out_data;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_N(6)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          f;
    int          k;
    logic [15:0] d;
    logic        l;
  } vec_t;

  vec_t        vt[12];
  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  int          waits = 0;
  int          cyc = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          got_cyc[$];
  logic [DW-1:0] m_buf[N];
  int          m_idx = 0;
  logic        m_mode = 1'b0;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic        prev_l = 1'b0;
  logic [16:0] e;
  bit          bp_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [5:0] br6(input logic [5:0] x);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i] = x[5-i];
    return r;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic mm);
    logic [5:0] a;
    if (m_idx == 0) m_mode = mm;
    m_buf[m_idx] = d;
    m_idx++;
    if (m_idx == N) begin
      for (int k = 0; k < N; k++) begin
        a = m_mode ? br6(6'(k)) : 6'(k);
        exp_q.push_back({(k == N-1), m_buf[a]});
      end
      m_idx = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_idx = 0;
  endtask

  // Offers one sample; returns #1 after the edge that accepted it.
  task automatic put(input logic [DW-1:0] d, input logic l);
    bit   ok;
    int   tries;
    logic mm;
    ok = 1'b0;
    tries = 0;
    mm = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      ok = in_ready;
      mm = mode;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 2000);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("put_accept", ok, 1'b1);
    if (ok) begin
      waits += tries - 1;
      acc_cnt++;
      model_accept(d, mm);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) break;
    end
    chk("drain_done", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard, stall stability and idle-zero checks.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_data", out_data, prev_d);
          chk("stall_last", out_last, prev_l);
        end
        if (!out_valid) begin
          chk("idle_data_zero", out_data, 0);
          chk("idle_last_zero", out_last, 0);
        end
        if (out_valid && out_ready) begin
          got_q.push_back({out_last, out_data});
          got_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("out_spurious", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", {out_last, out_data}, e);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_l     = out_last;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int xcnt;
    int idx;

    vt[0]  = '{0, 0, 16'd0, 1'b0};
    vt[1]  = '{0, 1, 16'd32, 1'b0};
    vt[2]  = '{0, 2, 16'd16, 1'b0};
    vt[3]  = '{0, 3, 16'd48, 1'b0};
    vt[4]  = '{0, 4, 16'd8, 1'b0};
    vt[5]  = '{0, 5, 16'd40, 1'b0};
    vt[6]  = '{0, 32, 16'd1, 1'b0};
    vt[7]  = '{0, 62, 16'd31, 1'b0};
    vt[8]  = '{0, 63, 16'd63, 1'b1};
    vt[9]  = '{1, 0, 16'd0, 1'b0};
    vt[10] = '{1, 17, 16'd17, 1'b0};
    vt[11] = '{1, 63, 16'd63, 1'b1};

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Bit-reversed frame with latency check
    mode = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      put(16'(i), i == N-1);
      if (i == N-2) chk("lat_before", out_valid, 0);
      if (i == N-1) chk("lat_after", out_valid, 1);
    end
    wait_drain();

    // Bypass frame
    mode = 1'b0;
    for (int i = 0; i < N; i++) put(16'(i), i == N-1);
    wait_drain();

    chk("table_frames", got_q.size(), 2*N);
    for (int v = 0; v < 12; v++) begin
      idx = vt[v].f * N + vt[v].k;
      chk($sformatf("vec%0d", v), got_q[idx], {vt[v].l, vt[v].d});
    end

    // Three back-to-back frames, mode toggled per frame and flipped mid-frame
    waits = 0;
    base = got_q.size();
    for (int f = 0; f < 3; f++) begin
      mode = (f % 2 == 0);
      for (int i = 0; i < N; i++) begin
        if (i == 20) mode = !mode;
        put(16'(16'h100 * (f + 1) + i), i == N-1);
      end
    end
    chk("stream_in_ready_waits", waits, 0);
    wait_drain();
    chk("stream_count", got_q.size() - base, 3*N);
    if (got_q.size() >= base + 3*N)
      chk("stream_gapless", got_cyc[base+3*N-1] - got_cyc[base], 3*N-1);

    // Backpressure: both banks fill, then drain releases the write side
    out_ready = 1'b0;
    mode = 1'b1;
    acc_cnt = 0;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 130; i++) put(16'(16'h400 + i), (i % N) == N-1);
        bp_done = 1'b1;
      end
    join_none
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!in_ready) break;
    end
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_accepts", acc_cnt, 128);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 16'h400);
      chk("bp_hold_last", out_last, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    xcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) xcnt++;
      if (xcnt == N) begin
        chk("bp_in_ready_before", in_ready, 0);
        @(negedge clk);
        chk("bp_in_ready_after", in_ready, 1);
        break;
      end
    end
    chk("bp_release", xcnt, N);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bp_done) break;
    end
    chk("bp_done", bp_done, 1);
    wait_drain();
    pulse_reset();

    // Framing error: early in_last, missing final in_last
    mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      put(16'(16'h500 + i), i == 10);
      if (i == 9) chk("ferr_before", frame_err, 0);
      if (i == 10) chk("ferr_set", frame_err, 1);
      if (i == N-2) chk("ferr_frame_open", out_valid, 0);
      if (i == N-1) chk("ferr_frame_end", out_valid, 1);
    end
    wait_drain();
    chk("ferr_sticky", frame_err, 1);

    // Mid-frame reset with a full bank stalled and a partial frame pending
    out_ready = 1'b0;
    mode = 1'b1;
    for (int i = 0; i < N; i++) put(16'(16'h600 + i), i == N-1);
    chk("ferr_still_set", frame_err, 1);
    for (int i = 0; i < 20; i++) put(16'(16'h700 + i), 1'b0);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_frame_err", frame_err, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    mode = 1'b1;
    base = got_q.size();
    for (int i = 0; i < N; i++) put(16'(16'h800 + i), i == N-1);
    wait_drain();
    chk("clean_count", got_q.size() - base, N);
    if (got_q.size() >= base + 2) begin
      chk("clean_first", got_q[base], {1'b0, 16'h800});
      chk("clean_second", got_q[base+1], {1'b0, 16'h820});
    end
    chk("clean_frame_err", frame_err, 0);
    chk("leftover_expected", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Streaming, parametrised successor to the block-wide FFT input sorter.
- Accepts complex-packed samples one per clock in natural order over a valid/ready handshake.
- Emits each frame of N = 2^LOG2_N samples in bit-reversed order, or in natural order in bypass mode.
- Double-buffered (ping-pong) so one frame fills while the previous drains. Sits between the ADC/sample front end and the FFT butterfly datapath.

Parameters:
- DATA_WIDTH, 16, bits per sample.
- LOG2_N, 6, log2 of frame length. N = 2^LOG2_N; legal range 1..10.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mode  in  1  1 = bit-reversed output, 0 = natural-order bypass. Sampled per frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_WIDTH  input sample.
- in_last  in  1  producer's end-of-frame marker. Checked only, never used for framing.
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts the sample.
- out_data  out  DATA_WIDTH  output sample.
- out_last  out  1  high with the final sample of each output frame.
- frame_err  out  1  sticky framing error flag.

Behaviour:
- Storage:
  - Two banks of N x DATA_WIDTH registers.
  - State: wr_bank, wr_idx[LOG2_N-1:0], rd_bank, rd_idx[LOG2_N-1:0], full[1:0], bank_mode[1:0].
- Reset (rst low, async):
  - wr_bank=rd_bank=0, wr_idx=rd_idx=0, full=0, bank_mode=0, frame_err=0.
  - Bank contents are not reset.
  - Outputs during and after reset: out_valid=0, out_last=0, out_data=0, in_ready=1.
- Input side:
  - in_ready = !full[wr_bank] (combinational from registered state).
  - Accept = in_valid & in_ready. On accept: bank[wr_bank][wr_idx] <= in_data and wr_idx <= wr_idx+1.
  - On accept with wr_idx==0: bank_mode[wr_bank] <= mode. A mode change mid-frame has no effect on that frame.
  - On accept with wr_idx==N-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx wraps to 0.
- Framing check:
  - On accept, set frame_err if in_last != (wr_idx==N-1).
  - frame_err clears only on reset. Framing always follows the internal count.
- Output side:
  - out_valid = full[rd_bank].
  - Read address = bitrev(rd_idx) if bank_mode[rd_bank] else rd_idx. bitrev reverses the LOG2_N bits.
  - out_data = bank[rd_bank][addr] when out_valid, else 0. This is a first-word-fall-through read.
  - out_last = out_valid & (rd_idx==N-1).
  - Transfer = out_valid & out_ready. On transfer, rd_idx increments.
  - On transfer with rd_idx==N-1: full[rd_bank] <= 0, rd_bank toggles, rd_idx wraps to 0.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - First out_valid occurs exactly 1 cycle after the edge that accepts sample N-1 of the frame.
  - Sustained throughput is 1 sample/clk each side with out_ready held high. in_ready never drops.
- Simultaneous events:
  - A write completion and a read completion in the same cycle touch different banks; both take effect.
  - A bank freed by the read side becomes writable the following cycle. There is no same-cycle bypass.
  - The write bank is never full and the read bank is always full when reading, so there is no read/write conflict on one bank.
- Backpressure: with both banks full, in_ready=0 until the drain of the rd_bank frame completes.
- Reset mid-operation: partial frames in both banks are discarded. The next accepted sample is index 0 of bank 0.

Test Plan:
- Frame order: LOG2_N=6, mode=1, in_data=i for i=0..63 back-to-back, out_ready=1.
  -> Outputs 0,32,16,48,8,40,... (bitrev6(k)).
  -> out_last only on the 64th output (value 63).
  -> First out_valid 1 cycle after sample 63 is accepted.
- Bypass: mode=0, same stimulus -> outputs 0..63 in order, out_last with 63.
- Streaming: 3 consecutive frames, mode toggled at each frame start, out_ready=1.
  -> in_ready stays 1 throughout.
  -> 192 outputs with no gaps after the first frame.
  -> Each frame is ordered per its own sampled mode.
  -> Flipping mode mid-frame changes nothing.
- Backpressure: out_ready=0, stream 130 samples.
  -> in_ready falls after 128 accepts.
  -> out_data/out_last stable while stalled.
  -> Raise out_ready: in_ready returns the cycle after the 64th transfer.
  -> All data intact.
- Framing error: in_last asserted on sample 10 and low on sample 63.
  -> frame_err=1 after sample 10 and stays 1.
  -> Frame still ends at sample 63.
  -> Only reset clears frame_err.
- Reset mid-frame: assert rst after 20 samples.
  -> out_valid=0, in_ready=1, frame_err=0 immediately (asynchronous).
  -> Next 64 samples form a clean frame starting at index 0.
